// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default width and FSM states.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

endpackage : serial_sub_pkg

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bi, with borrow out bo.
// Purely combinational; the serial datapath reuses this single cell every cycle.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow generation/propagation.
  always_comb begin
    d  = a ^ b ^ bi;
    bo = (~a & b) | (~(a ^ b) & bi);
  end

endmodule : full_subtractor_cell

// File: rtl/serial_sub6.sv
// Bit-serial subtractor, diff = a - b - bin, one bit per clock, LSB first.
// A start in IDLE or DONE captures the operands; WIDTH RUN cycles later the
// result is presented with a one-cycle done pulse and held until the next start.
// Optional macro SUB_FLAGS_EN adds zero and two's-complement overflow flags.
module serial_sub6
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sub_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             d_s, bo_s;
  logic [WIDTH-1:0] diff_next_s;
`ifdef SUB_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // Single shared bit cell fed by the operand LSBs and the running borrow.
  full_subtractor_cell u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .bi (br_q),
    .d  (d_s),
    .bo (bo_s)
  );

  // Result register contents after shifting in the current difference bit.
  always_comb begin
    diff_next_s = {d_s, diff_q[WIDTH-1:1]};
  end

  // Next-state, datapath and flag logic; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SUB_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          br_d    = bin;
          cnt_d   = {CNT_W{1'b0}};
          diff_d  = {WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = bo_s;
        diff_d = diff_next_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          bout_d  = bo_s;
          done_d  = 1'b1;
`ifdef SUB_FLAGS_EN
          // On the last bit the shift-register LSBs are the operand MSBs.
          zero_d  = (diff_next_s == {WIDTH{1'b0}});
          ovf_d   = (a_sh_q[0] != b_sh_q[0]) && (d_s != a_sh_q[0]);
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

`ifdef SUB_FLAGS_EN
  // Result flag registers, updated together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  // Flag outputs straight from their registers.
  always_comb begin
    zero = zero_q;
    ovf  = ovf_q;
  end
`endif

  // Outputs are direct register values or a decode of the state register.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = done_q;
    diff = diff_q;
    bout = bout_q;
  end

endmodule : serial_sub6

// File: tb/tb_serial_sub6.sv
// Directed self-checking bench for serial_sub6 (WIDTH = 6).
// Expected values are hand-computed constants; outputs are sampled 1 ns after
// the rising edge. Flag checks are active when SUB_FLAGS_EN is defined.
module tb_serial_sub6;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] a_in;
  logic [5:0] b_in;
  logic       bin;
  logic       busy;
  logic       done;
  logic [5:0] diff;
  logic       bout;
`ifdef SUB_FLAGS_EN
  logic       zero;
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_sub6 #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_FLAGS_EN
    ,
    .zero  (zero),
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic launch(input logic [5:0] a, input logic [5:0] b, input logic bi);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    bin   = bi;
    tick();
    start = 1'b0;
    a_in  = 6'($urandom);
    b_in  = 6'($urandom);
    bin   = 1'($urandom);
  endtask

  // Walk the WIDTH busy cycles, optionally pulsing ignored starts, then check the result.
  task automatic run_check(input string tag, input logic poke,
                           input logic [5:0] ed, input logic eb,
                           input logic ez, input logic eo);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
      chk({tag, "_nodone"}, {7'd0, done}, 8'd0);
      if (poke && (i == 2 || i == 4)) begin
        start = 1'b1;
        a_in  = 6'd1;
        b_in  = 6'd60;
        bin   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_busy_off"}, {7'd0, busy}, 8'd0);
    chk({tag, "_diff"}, {2'd0, diff}, {2'd0, ed});
    chk({tag, "_bout"}, {7'd0, bout}, {7'd0, eb});
`ifdef SUB_FLAGS_EN
    chk({tag, "_zero"}, {7'd0, zero}, {7'd0, ez});
    chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, eo});
`else
    if (ez === 1'bx || eo === 1'bx) chk({tag, "_flag_args"}, 8'd0, 8'd1);
`endif
  endtask

  // One idle cycle after done: pulse gone, result held.
  task automatic idle_check(input string tag, input logic [5:0] ed, input logic eb);
    tick();
    chk({tag, "_pulse1"}, {7'd0, done}, 8'd0);
    chk({tag, "_idle"}, {7'd0, busy}, 8'd0);
    chk({tag, "_hold"}, {2'd0, diff}, {2'd0, ed});
    chk({tag, "_holdb"}, {7'd0, bout}, {7'd0, eb});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 6'd0;
    b_in  = 6'd0;
    bin   = 1'b0;
    #3;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_diff", {2'd0, diff}, 8'd0);
    chk("rst_bout", {7'd0, bout}, 8'd0);
`ifdef SUB_FLAGS_EN
    chk("rst_zero", {7'd0, zero}, 8'd0);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // 13 - 5 = 8
    launch(6'd13, 6'd5, 1'b0);
    run_check("t13m5", 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
    idle_check("t13m5", 6'd8, 1'b0);

    // 5 - 13 = -8 -> 56, borrow
    launch(6'd5, 6'd13, 1'b0);
    run_check("t5m13", 1'b0, 6'd56, 1'b1, 1'b0, 1'b0);
    idle_check("t5m13", 6'd56, 1'b1);

    // 0 - 0 - 1 = 63, borrow
    launch(6'd0, 6'd0, 1'b1);
    run_check("t0m0b", 1'b0, 6'd63, 1'b1, 1'b0, 1'b0);
    idle_check("t0m0b", 6'd63, 1'b1);

    // 9 - 9 = 0, zero flag
    launch(6'd9, 6'd9, 1'b0);
    run_check("t9m9", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    idle_check("t9m9", 6'd0, 1'b0);

    // -32 - 1 = 31 with signed overflow
    launch(6'd32, 6'd1, 1'b0);
    run_check("t32m1", 1'b0, 6'd31, 1'b0, 1'b0, 1'b1);
    idle_check("t32m1", 6'd31, 1'b0);

    // 20 - 7 = 13 with ignored starts while busy, then start in DONE cycle
    launch(6'd20, 6'd7, 1'b0);
    run_check("tign", 1'b1, 6'd13, 1'b0, 1'b0, 1'b0);
    // 40 - 50 = -10 -> 54, borrow; same-sign operands so no overflow
    launch(6'd40, 6'd50, 1'b0);
    chk("b2b_diff_clr", {2'd0, diff}, 8'd0);
    run_check("tb2b", 1'b0, 6'd54, 1'b1, 1'b0, 1'b0);
    idle_check("tb2b", 6'd54, 1'b1);

    // Reset in busy cycle 3 aborts the operation
    launch(6'd7, 6'd3, 1'b0);
    tick();
    tick();
    chk("abort_busy_pre", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_diff", {2'd0, diff}, 8'd0);
    chk("abort_bout", {7'd0, bout}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_nodone", {7'd0, done}, 8'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {7'd0, busy}, 8'd0);
    chk("post_rst_done", {7'd0, done}, 8'd0);

    // 25 - 10 = 15 after reset release
    launch(6'd25, 6'd10, 1'b0);
    run_check("t25m10", 1'b0, 6'd15, 1'b0, 1'b0, 1'b0);
    idle_check("t25m10", 6'd15, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_sub6
